clk_step_ctrl: RTL

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

---
 rtl/clk_step_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clk_step_ctrl.sv
// Run/step/lock clock-enable sequencer: emits one-cycle tick pulses at a selectable period or on single-step.
// Inputs pass 2-FF synchronizers; a step edge ticks 3 edges later, free-run ticks land in the P-th RUN cycle.
module clk_step_ctrl #(
    parameter int DIV0  = 50000000,
    parameter int DIV1  = 5000000,
    parameter int DIV2  = 500000,
    parameter int CNT_W = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  div_sel,
    input  logic        halt_req,
    output logic        tick,
    output logic        slow_led,
    output logic [1:0]  state,
    output logic [15:0] tick_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOCK = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] DIV0_M1 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] DIV1_M1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] DIV2_M1 = CNT_W'(DIV2 - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        div_q, div_d;
    logic              run_s1_q, run_s1_d, run_s2_q, run_s2_d;
    logic              step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_s3_q, step_s3_d;
    logic              slow_led_q, slow_led_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;

    logic [CNT_W-1:0]  per_m1;
    logic              step_rise;
    logic              run_on;
    logic              term;

    always_comb begin
        case (div_q)
            2'b00:   per_m1 = DIV0_M1;
            2'b01:   per_m1 = DIV1_M1;
            2'b10:   per_m1 = DIV2_M1;
            default: per_m1 = '0;
        endcase
    end

    assign step_rise = step_s2_q & ~step_s3_q;
    assign run_on    = run_s2_q;
    assign term      = (cnt_q == per_m1);
    assign tick      = (state_q == ST_STEP) | ((state_q == ST_RUN) & term);

    always_comb begin
        run_s1_d  = run_sw;
        run_s2_d  = run_s1_q;
        step_s1_d = step_btn;
        step_s2_d = step_s1_q;
        step_s3_d = step_s2_q;
        div_d     = div_sel;
    end

    // Step edges seen outside HALT fall through every branch and are lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (run_on)         state_d = ST_RUN;
                else if (step_rise) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (halt_req)       state_d = ST_LOCK;
                else if (!run_on)   state_d = ST_HALT;
            end
            ST_STEP: state_d = halt_req ? ST_LOCK : ST_HALT;
            ST_LOCK: begin
                if (!run_on)        state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // A div_sel change restarts the period so the new rate starts from a clean count.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && (div_sel == div_q) && !term)
            cnt_d = cnt_q + CNT_W'(1);
        slow_led_d = slow_led_q ^ tick;
        tick_cnt_d = tick_cnt_q + {15'd0, tick};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HALT;
            cnt_q      <= '0;
            div_q      <= 2'b00;
            run_s1_q   <= 1'b0;
            run_s2_q   <= 1'b0;
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            step_s3_q  <= 1'b0;
            slow_led_q <= 1'b0;
            tick_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            run_s1_q   <= run_s1_d;
            run_s2_q   <= run_s2_d;
            step_s1_q  <= step_s1_d;
            step_s2_q  <= step_s2_d;
            step_s3_q  <= step_s3_d;
            slow_led_q <= slow_led_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign state    = state_q;
    assign slow_led = slow_led_q;
    assign tick_cnt = tick_cnt_q;

endmodule
